uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each received byte once per `rx_done` assertion, even though `rx_done` is a level held for many clocks. Stores bytes in a circular FIFO and presents them first-word-fall-through to the consumer (command decoder / loopback tx path). Reports full, empty, occupancy and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 8: byte width; must match the receiver's `rx_data`.
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: derived; never overridden.

- `clk` in 1: system clock (100 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in `DATA_WIDTH`: received byte; valid whenever `rx_done` is high.
- `rx_done` in 1: receiver completion level; may stay high for many cycles per byte.
- `rd_en` in 1: pop request; acts only when `empty`=0.
- `ovf_clr` in 1: clears `overflow`.
- `rd_data` out `DATA_WIDTH`: head entry; 0 when `empty`.
- `empty` out 1: no entries.
- `full` out 1: `DEPTH` entries.
- `count` out `ADDR_WIDTH+1`: occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky; a byte was dropped.

## Operation
- Edge detect: register `rx_done_d`. `push_req = rx_done & ~rx_done_d`. Exactly one push per low-to-high transition of `rx_done`, regardless of how long it stays high.
- Pointers: `wr_ptr` and `rd_ptr` are `ADDR_WIDTH+1` bits wide. The low bits address storage and the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count = wr_ptr - rd_ptr`, modulo 2^(`ADDR_WIDTH+1`).
- Push (`push_req` and not full): write `rx_data` at `wr_ptr[ADDR_WIDTH-1:0]`, then `wr_ptr+1`.
- Pop (`rd_en` and not empty): `rd_ptr+1`. `rd_data` combinationally shows `mem[rd_ptr]`, forced to 0 when empty.
- Boundary rules:
  - Push while full, no pop: byte dropped, pointers unchanged, `overflow` set.
  - Push and pop same cycle, not full and not empty: both execute, `count` unchanged.
  - Push and pop same cycle while full: both execute, no overflow, `count` stays `DEPTH`. Written slot is the one freed by the pop.
  - Push and pop same cycle while empty: push only. Pop ignored, `rd_data` remains 0 that cycle.
  - Pop while empty: ignored, no state change.
  - Pointer wrap: increments roll over naturally. Ordering is preserved across any number of wraps.
  - `ovf_clr` and a new overflow in the same cycle: set wins.
- Reset (any time, including mid-push):
  - Pointers 0, `overflow`=0, `rx_done_d`=1.
  - Because `rx_done_d` resets to 1, a `rx_done` held high across reset release is not captured.
  - Storage contents are not reset.

## Timing
- Reset values: `rd_data`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
- Push latency: for the first edge where `rx_done`=1 is sampled, the write occurs at that edge. In the following cycle `empty`=0, `count` increments and `rd_data`=byte.
- Pop: `rd_en` sampled high at edge N advances the head. The new `rd_data`, `count` and `empty` are valid after edge N.
- `overflow` asserts the cycle after the dropped push. It clears the cycle after `ovf_clr` is sampled.
- `full`, `empty` and `count` are derived from registered pointers only; no combinational path from inputs.
- `rd_data` is combinational from `rd_ptr` and storage only; no combinational path from `rd_en`.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_WIDTH` = 8.
  - `UART_RX_FIFO_DEPTH` = 16.
  - Shared with the receiver and tick generator.
- Sub-module `fifo_regfile`:
  - `DEPTH` x `DATA_WIDTH` array, synchronous write with enable, asynchronous read.
  - No reset on storage.
- Top `uart_rx_fifo` holds the edge detector, pointers, flags and the empty-forcing mux on `rd_data`.

## Test plan
- Reset then single byte: `rx_done` held high 200 cycles with `rx_data`=0x41 -> exactly one push. `count`=1, `rd_data`=0x41. After one `rd_en` pulse: `empty`=1, `rd_data`=0.
- Fill and overflow: push 0x00..0x0F, then a 17th byte 0xAA -> `full`=1, `overflow`=1. Popping 16 times returns 0x00..0x0F in order and 0xAA never appears.
- Simultaneous push/pop at full: full with head 0x00; push 0x55 in the same cycle as `rd_en` -> `count` stays 16, `overflow`=0. 0x55 emerges as the last of the next 16 pops.
- Wrap-around: 40 push/pop pairs with interleaved occupancy 0..5, values 0x10..0x37 -> output sequence identical to input. `count` matches the model every cycle.
- Empty pop and overflow clear: `rd_en` while empty -> no pointer change, `count`=0. Assert `ovf_clr` in the same cycle as an overflowing push -> `overflow` stays 1. A later `ovf_clr` alone -> 0.
- Reset mid-operation: with 5 entries, assert `rst` while `rx_done`=1 and keep `rx_done` high past release -> `empty`=1, `count`=0, and no push until `rx_done` falls and rises again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART build constants used by the receiver, tick generator and rx FIFO.
package uart_pkg;
    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: synchronous write with enable, asynchronous read, no reset on contents.
module fifo_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: one push per rising edge of rx_done, first-word-fall-through read,
// full/empty/count from wrap-bit pointers and a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_RX_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       rx_done,
    input  logic                       rd_en,
    input  logic                       ovf_clr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  rx_done_d;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  push_req;
    logic                  do_push;
    logic                  do_pop;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] head_data;

    assign push_req = rx_done & ~rx_done_d;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a push at full still goes through.
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_req & (~full | do_pop);
    assign ovf_set = push_req & full & ~do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done_d <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            rx_done_d <= rx_done;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (head_data)
    );

    assign rd_data = empty ? '0 : head_data;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic          rd_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [4:0]    count;
    logic          overflow;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf  = 1'b0;
    bit            m_prev = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    endtask

    // Advance one clock, apply the queue semantics to the model, then check at the falling edge.
    task automatic tick();
        bit push;
        bit pop;
        bit set;
        @(posedge clk);
        push = rx_done && !m_prev;
        pop  = rd_en && (q.size() != 0);
        set  = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(rx_data);
            else set = 1'b1;
        end
        if (set) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_prev = rx_done;
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit d, input logic [DW-1:0] data, input bit r, input bit c);
        rx_done = d;
        rx_data = data;
        rd_en   = r;
        ovf_clr = c;
        tick();
    endtask

    task automatic push_byte(input logic [DW-1:0] data);
        drive(1'b1, data, 1'b0, 1'b0);
        drive(1'b1, data, 1'b0, 1'b0);
        drive(1'b0, data, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int unsigned cycles);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b1;
        #1;
        check_all();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned pushed;
        int unsigned cyc;
        logic [DW-1:0] b;

        // Reset state
        do_reset(2);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Long rx_done level produces exactly one push
        for (int i = 0; i < 200; i++) drive(1'b1, 8'h41, 1'b0, 1'b0);
        check("single_count", 32'(count), 32'd1);
        check("single_data", 32'(rd_data), 32'h41);
        drive(1'b0, 8'h41, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("single_drained", 32'(empty), 32'd1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'hAA);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        check("pp_full_count", 32'(count), 32'd16);
        check("pp_full_ovf", 32'(overflow), 32'd0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b0, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("pp_full_order", 32'(rd_data), (i == 15) ? 32'h55 : 32'(i + 1));
            drive(1'b0, '0, 1'b1, 1'b0);
        end

        // Randomized wrap-around traffic, occupancy kept within 0..5
        pushed = 0;
        for (cyc = 0; cyc < 2000 && (pushed < 40 || q.size() != 0); cyc++) begin
            bit d;
            bit r;
            r = (q.size() != 0) && (q.size() >= 5 || $urandom_range(0, 2) == 0);
            d = 1'b0;
            if (!rx_done && pushed < 40 && q.size() < 5 && $urandom_range(0, 1) == 1) begin
                d = 1'b1;
                pushed++;
            end
            drive(d, d ? 8'(8'h10 + pushed - 1) : rx_data, r, 1'b0);
        end
        check("wrap_done", 32'(cyc < 2000), 32'd1);

        // Pop while empty, then overflow with a simultaneous clear
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("empty_pop_count", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            push_byte(b);
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        drive(1'b0, 8'hEE, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Reset during a push with rx_done held through release
        for (int i = 0; i < 11; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        do_reset(3);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h77, 1'b0, 1'b0);
        check("rst_hold_empty", 32'(empty), 32'd1);
        drive(1'b0, 8'h77, 1'b0, 1'b0);
        drive(1'b1, 8'h78, 1'b0, 1'b0);
        check("rst_repush", 32'(rd_data), 32'h78);
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
